// File: rtl/dma_burst_mem_responder.sv
// dma_burst_mem_responder
// Memory-side responder for the DMA burst master. Accepts a burst command in
// IDLE, applies a DRAM-style open-row penalty on a row change, then streams
// read beats (r_valid) or accepts write beats (w_valid) against an internal
// word-addressed array of 2^ADDR_W x 32-bit words.
//
// Optional build macro: DMA_RESP_ROWCHK_EN
//   defined   - bursts that run past word 1023 of their 4 KB row set the sticky
//               row_err flag; beats beyond the row end are suppressed (writes
//               dropped, reads return zero) while the handshake count is kept.
//   undefined - row_err stays 0 and beat addresses run linearly across rows.
module dma_burst_mem_responder #(
  parameter int ADDR_W       = 14,
  parameter int RD_LAT       = 2,
  parameter int ROW_MISS_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CEB,
  input  logic        WEB,
  input  logic [31:0] addr,
  input  logic [3:0]  bweb,
  input  logic [31:0] write_data,
  input  logic [3:0]  burst_len,
  output logic [31:0] readData,
  output logic        r_valid,
  output logic        w_valid,
  output logic        row_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACT  = 3'd1;
  localparam logic [2:0] S_RLAT = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_TURN = 3'd5;

  localparam int ROW_W = ADDR_W - 10;
  localparam int CNT_W = 8;

  // Last count value of the row-activation and read-latency phases.
  localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ROW_MISS_LAT > 0 ? ROW_MISS_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] RLAT_LAST = CNT_W'(RD_LAT > 1 ? RD_LAT - 2 : 0);
  // With RD_LAT == 1 there is no latency phase: reads go straight to beats.
  localparam logic [2:0]       S_RD_ENTRY = (RD_LAT > 1) ? S_RLAT : S_RD;

  logic [31:0] mem [2**ADDR_W];

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        len_q, len_d;
  logic              dir_q, dir_d;          // 1 = read burst
  logic [3:0]        beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  open_row_q, open_row_d;
  logic              open_vld_q, open_vld_d;
  logic              row_err_q, row_err_d;
  logic              r_valid_q, w_valid_q;
  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] cmd_word;
  logic [ROW_W-1:0]  cmd_row;
  logic              row_miss;
  logic [2:0]        after_act;
  logic              rd_fire;
  logic [ADDR_W-1:0] rd_idx, wr_idx;
  logic              rd_cross, wr_cross;
  logic              wr_en;
  logic              unused_addr;

  assign cmd_word    = addr[ADDR_W+1:2];
  assign cmd_row     = addr[ADDR_W+1:12];
  assign row_miss    = !open_vld_q || (cmd_row != open_row_q);
  assign after_act   = dir_q ? S_RD_ENTRY : S_WR;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  // Array index of the beat being read next cycle, and of the beat being
  // written this cycle; both wrap modulo the array size.
  assign rd_fire = (state_d == S_RD);
  assign rd_idx  = base_d + {{(ADDR_W-4){1'b0}}, beat_d};
  assign wr_idx  = base_q + {{(ADDR_W-4){1'b0}}, beat_q};

`ifdef DMA_RESP_ROWCHK_EN
  logic [10:0] rd_off, wr_off;
  logic [10:0] cmd_end;
  assign rd_off   = {1'b0, base_d[9:0]} + {7'b0, beat_d};
  assign wr_off   = {1'b0, base_q[9:0]} + {7'b0, beat_q};
  assign cmd_end  = {1'b0, addr[11:2]} + {7'b0, burst_len};
  assign rd_cross = rd_off[10];
  assign wr_cross = wr_off[10];
`else
  assign rd_cross = 1'b0;
  assign wr_cross = 1'b0;
`endif

  assign wr_en = w_valid_q && !wr_cross;

  // Next-state logic: command accept, row activation, latency and beat counting.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    dir_d      = dir_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    open_row_d = open_row_q;
    open_vld_d = open_vld_q;
    row_err_d  = row_err_q;
    case (state_q)
      S_IDLE: begin
        if (!CEB) begin
          base_d     = cmd_word;
          len_d      = burst_len;
          dir_d      = WEB;
          beat_d     = 4'd0;
          cnt_d      = '0;
          open_row_d = cmd_row;
          open_vld_d = 1'b1;
`ifdef DMA_RESP_ROWCHK_EN
          if (cmd_end > 11'd1023) row_err_d = 1'b1;
`endif
          if (row_miss && (ROW_MISS_LAT > 0)) state_d = S_ACT;
          else                                state_d = WEB ? S_RD_ENTRY : S_WR;
        end
      end
      S_ACT: begin
        if (CEB) begin
          state_d = S_TURN;
        end else if (cnt_q == ACT_LAST) begin
          cnt_d   = '0;
          state_d = after_act;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RLAT: begin
        if (CEB) begin
          state_d = S_TURN;
        end else if (cnt_q == RLAT_LAST) begin
          cnt_d   = '0;
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD, S_WR: begin
        if (CEB || (beat_q == len_q)) state_d = S_TURN;
        else                          beat_d  = beat_q + 4'd1;
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, open-row tracking and registered beat outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      dir_q      <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= '0;
      open_row_q <= '0;
      open_vld_q <= 1'b0;
      row_err_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      w_valid_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      open_row_q <= open_row_d;
      open_vld_q <= open_vld_d;
      row_err_q  <= row_err_d;
      r_valid_q  <= (state_d == S_RD);
      w_valid_q  <= (state_d == S_WR);
      if (rd_fire) rdata_q <= rd_cross ? 32'h0 : mem[rd_idx];
    end
  end

  // Byte-masked array write on each accepted write beat.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents are undefined until written.
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (!bweb[b]) mem[wr_idx][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
  end

  assign readData = rdata_q;
  assign r_valid  = r_valid_q;
  assign w_valid  = w_valid_q;
  assign row_err  = row_err_q;

endmodule

// File: tb/tb_dma_burst_mem_responder.sv
// Testbench for dma_burst_mem_responder: directed write/read bursts with a
// byte-level memory model, a read-data scoreboard queue and an open-row model
// that predicts the beat timing. Honours DMA_RESP_ROWCHK_EN when defined.
module tb_dma_burst_mem_responder;

  localparam int ADDR_W       = 14;
  localparam int RD_LAT       = 2;
  localparam int ROW_MISS_LAT = 3;
`ifdef DMA_RESP_ROWCHK_EN
  localparam bit ROWCHK = 1'b1;
`else
  localparam bit ROWCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        CEB = 1'b1;
  logic        WEB = 1'b1;
  logic [31:0] addr = '0;
  logic [3:0]  bweb = 4'hf;
  logic [31:0] write_data = '0;
  logic [3:0]  burst_len = '0;
  logic [31:0] readData;
  logic        r_valid;
  logic        w_valid;
  logic        row_err;

  dma_burst_mem_responder #(
    .ADDR_W      (ADDR_W),
    .RD_LAT      (RD_LAT),
    .ROW_MISS_LAT(ROW_MISS_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .CEB       (CEB),
    .WEB       (WEB),
    .addr      (addr),
    .bweb      (bweb),
    .write_data(write_data),
    .burst_len (burst_len),
    .readData  (readData),
    .r_valid   (r_valid),
    .w_valid   (w_valid),
    .row_err   (row_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  bit          open_vld = 1'b0;
  int          open_row = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Open-row model: returns the expected command-to-first-beat latency.
  task automatic row_model(input logic [31:0] a, input bit rd, output int lat);
    int row;
    bit hit;
    row      = int'(a[ADDR_W+1:12]);
    hit      = open_vld && (row == open_row);
    open_vld = 1'b1;
    open_row = row;
    lat      = (rd ? RD_LAT : 1) + (hit ? 0 : ROW_MISS_LAT);
  endtask

  function automatic int widx(input logic [31:0] a, input int beat);
    return (int'(a[ADDR_W+1:2]) + beat) % (1 << ADDR_W);
  endfunction

  function automatic bit crosses(input logic [31:0] a, input int beat);
    return ROWCHK && ((int'(a[11:2]) + beat) > 1023);
  endfunction

  task automatic do_write(input string tag, input logic [31:0] a, input int len,
                          input logic [3:0] mask, input logic [31:0] d0, input logic [31:0] step);
    int lat, beats, t0, wi;
    logic [31:0] d, tmp;
    row_model(a, 1'b0, lat);
    @(negedge clk);
    CEB = 1'b0; WEB = 1'b0; addr = a; burst_len = 4'(len);
    bweb = 4'h0; write_data = 32'hBAD0BAD0;
    t0 = cyc;
    beats = 0;
    for (int k = 0; k < 64 && beats <= len; k++) begin
      @(negedge clk);
      if (w_valid) begin
        check($sformatf("%s_wt%0d", tag, beats), 32'(cyc - t0), 32'(lat + beats));
        d = d0 + 32'(beats) * step;
        write_data = d;
        bweb = mask;
        if (!crosses(a, beats)) begin
          wi  = widx(a, beats);
          tmp = model.exists(wi) ? model[wi] : 32'h0;
          for (int b = 0; b < 4; b++) if (!mask[b]) tmp[8*b +: 8] = d[8*b +: 8];
          model[wi] = tmp;
        end
        beats++;
        if (beats == len + 1) CEB = 1'b1;
      end else begin
        write_data = 32'hBAD0BAD0;
        bweb = 4'h0;
      end
    end
    CEB = 1'b1;
    check($sformatf("%s_wbeats", tag), 32'(beats), 32'(len + 1));
    @(negedge clk);
    write_data = 32'hBAD0BAD0;
    bweb = 4'h0;
    check($sformatf("%s_wend", tag), {31'h0, w_valid}, 32'h0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input int len,
                         input int abort_after, input bit chk_data);
    int lat, beats, t0, stop, wi;
    exp_t e;
    row_model(a, 1'b1, lat);
    for (int i = 0; i <= len; i++) begin
      wi     = widx(a, i);
      e.data = crosses(a, i) ? 32'h0 : (model.exists(wi) ? model[wi] : 32'h0);
      e.chk  = chk_data;
      sb.push_back(e);
    end
    stop = (abort_after > 0) ? abort_after : len + 1;
    @(negedge clk);
    CEB = 1'b0; WEB = 1'b1; addr = a; burst_len = 4'(len); bweb = 4'hf;
    t0 = cyc;
    beats = 0;
    for (int k = 0; k < 64 && beats < stop; k++) begin
      @(negedge clk);
      if (r_valid) begin
        check($sformatf("%s_rt%0d", tag, beats), 32'(cyc - t0), 32'(lat + beats));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (e.chk) check($sformatf("%s_d%0d", tag, beats), readData, e.data);
        end
        beats++;
        if (beats == stop) CEB = 1'b1;
      end
    end
    CEB = 1'b1;
    check($sformatf("%s_rbeats", tag), 32'(beats), 32'(stop));
    @(negedge clk);
    check($sformatf("%s_rend", tag), {31'h0, r_valid}, 32'h0);
    sb.delete();
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_r_valid", {31'h0, r_valid}, 32'h0);
    check("rst_w_valid", {31'h0, w_valid}, 32'h0);
    check("rst_readData", readData, 32'h0);
    check("rst_row_err", {31'h0, row_err}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Write burst on a cold row, then read it back as a row hit
    do_write("wr1", 32'h0000_0100, 3, 4'h0, 32'h11, 32'h11);
    do_read ("rd1", 32'h0000_0100, 3, 0, 1'b1);

    // Byte-masked single-beat write and read back
    do_write("wrm", 32'h0000_0100, 0, 4'b1010, 32'hAABBCCDD, 32'h0);
    do_read ("rdm", 32'h0000_0100, 0, 0, 1'b1);
    check("mask_value", model[32'h40], 32'h00BB00DD);

    // Row miss then row hit on row 2 (timing only; contents never written)
    do_read("rmiss", 32'h0000_2000, 0, 0, 1'b0);
    do_read("rhit",  32'h0000_2010, 0, 0, 1'b0);

    // Read abort after the 3rd beat, then a command two cycles after that beat
    do_read("rabort", 32'h0000_0100, 7, 3, 1'b1);
    do_read("rnext",  32'h0000_0104, 0, 0, 1'b1);

    // Row boundary: seed the first words of row 1, then cross into it
    do_write("seed", 32'h0000_1000, 1, 4'h0, 32'hDEAD0400, 32'h1);
    check("row_err_pre", {31'h0, row_err}, 32'h0);
    do_write("wrow", 32'h0000_0FF8, 3, 4'h0, 32'hA0A0A0A0, 32'h1);
    check("row_err_post", {31'h0, row_err}, {31'h0, ROWCHK});
    do_read("rrow",  32'h0000_0FF8, 3, 0, 1'b1);
    do_read("rrow1", 32'h0000_1000, 1, 0, 1'b1);

    // Address wrap modulo the array size
    do_write("wwrap", 32'h0001_0000, 0, 4'h0, 32'h5A5A5A5A, 32'h0);
    do_read ("rwrap", 32'h0000_0000, 0, 0, 1'b1);

    // Maximum burst length (16 beats)
    do_write("w16", 32'h0000_0200, 15, 4'h0, 32'h10000000, 32'h01010101);
    do_read ("r16", 32'h0000_0200, 15, 0, 1'b1);
    check("row_err_end", {31'h0, row_err}, {31'h0, ROWCHK});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
